// File: rtl/alu_out_mux_buf_if.sv
// rtl/alu_out_mux_buf_if.sv - producer/consumer handshake and error-status bundle for alu_out_mux_buf
interface alu_out_mux_buf_if #(
    parameter int output_data_width = 8,
    parameter int channel_count     = 4,
    parameter int sel_width         = 2
);
    logic [channel_count*output_data_width-1:0] in_bus;
    logic [sel_width-1:0]                       sel;
    logic                                       in_valid;
    logic                                       in_ready;
    logic [output_data_width-1:0]               out;
    logic [sel_width-1:0]                       out_channel;
    logic                                       out_valid;
    logic                                       out_ready;
    logic                                       sel_error;
    logic [7:0]                                 drop_count;
    logic                                       err_clr;

    modport master (
        output in_bus, sel, in_valid, out_ready, err_clr,
        input  in_ready, out, out_channel, out_valid, sel_error, drop_count
    );

    modport slave (
        input  in_bus, sel, in_valid, out_ready, err_clr,
        output in_ready, out, out_channel, out_valid, sel_error, drop_count
    );
endinterface

// File: rtl/alu_out_mux_buf.sv
// rtl/alu_out_mux_buf.sv - channel selector feeding a 2-entry skid FIFO with out-of-range drop accounting
module alu_out_mux_buf #(
    parameter int output_data_width = 8,
    parameter int channel_count     = 4,
    parameter int sel_width         = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_out_mux_buf_if.slave  bus
);
    localparam int W = output_data_width;

    logic [W-1:0]         data_q [2];
    logic [sel_width-1:0] chan_q [2];
    logic [1:0]           count;
    logic                 head;
    logic                 tail;
    logic                 sel_err_q;
    logic [7:0]           drop_q;

    logic [W-1:0]         sel_data;
    logic                 sel_ok;
    logic                 accept;
    logic                 push;
    logic                 drop;
    logic                 pop;

    // Only in-range indices are decoded, so the slice never reaches past in_bus.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < channel_count; k++) begin
            if (bus.sel == sel_width'(k)) begin
                sel_data = bus.in_bus[k*W +: W];
                sel_ok   = 1'b1;
            end
        end
    end

    assign bus.in_ready    = (count < 2'd2) && !rst;
    assign accept          = bus.in_valid && bus.in_ready;
    assign push            = accept && sel_ok;
    assign drop            = accept && !sel_ok;
    assign bus.out_valid   = (count != 2'd0);
    assign pop             = bus.out_valid && bus.out_ready;
    assign bus.out         = bus.out_valid ? data_q[head] : '0;
    assign bus.out_channel = bus.out_valid ? chan_q[head] : '0;
    assign bus.sel_error   = sel_err_q;
    assign bus.drop_count  = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            head      <= 1'b0;
            tail      <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            chan_q[0] <= '0;
            chan_q[1] <= '0;
            sel_err_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            if (push) begin
                data_q[tail] <= sel_data;
                chan_q[tail] <= bus.sel;
                tail         <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            // A drop in the clearing cycle still counts as the first new drop.
            if (drop) begin
                sel_err_q <= 1'b1;
                if (bus.err_clr) begin
                    drop_q <= 8'd1;
                end else if (drop_q != 8'hff) begin
                    drop_q <= drop_q + 8'd1;
                end
            end else if (bus.err_clr) begin
                sel_err_q <= 1'b0;
                drop_q    <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_alu_out_mux_buf.sv
// tb/tb_alu_out_mux_buf.sv - self-checking bench for alu_out_mux_buf (4-channel and 3-channel instances)
module tb_alu_out_mux_buf;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    localparam logic [31:0] BUS4 = {8'h44, 8'h33, 8'h22, 8'h11};

    alu_out_mux_buf_if #(.output_data_width(8), .channel_count(4), .sel_width(2)) b4 ();
    alu_out_mux_buf_if #(.output_data_width(8), .channel_count(3), .sel_width(2)) b3 ();

    alu_out_mux_buf #(.output_data_width(8), .channel_count(4), .sel_width(2)) dut4 (
        .clk(clk), .rst(rst), .bus(b4)
    );
    alu_out_mux_buf #(.output_data_width(8), .channel_count(3), .sel_width(2)) dut3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       in_valid;
        logic       out_ready;
        logic       e_ready;
        logic       e_valid;
        logic [7:0] e_out;
        logic [1:0] e_chan;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b4.in_bus = '0; b4.sel = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.err_clr = 1'b0;
        b3.in_bus = '0; b3.sel = '0; b3.in_valid = 1'b0; b3.out_ready = 1'b0; b3.err_clr = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_in_ready4", b4.in_ready, 0);
        chk("rst_in_ready3", b3.in_ready, 0);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    vec_t       vec [9];
    ent_t       q [$];
    logic [7:0] pd;
    logic [1:0] ps;
    logic       m_err;
    int         m_drops;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //            sel   iv    ordy  e_rdy e_vld e_out   e_chan
        vec[0] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        vec[1] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
        vec[2] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vec[3] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0};
        vec[4] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0};
        vec[5] = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 2'd0};
        vec[6] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
        vec[7] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3};
        vec[8] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};

        do_reset();
        chk("reset_ready", b4.in_ready, 1);
        chk("reset_valid", b4.out_valid, 0);
        chk("reset_out", b4.out, 0);
        chk("reset_chan", b4.out_channel, 0);
        chk("reset_sel_error", b4.sel_error, 0);
        chk("reset_drop_count", b4.drop_count, 0);

        // Single transfer and back-pressure fill/drain
        b4.in_bus = BUS4;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("vec%0d_ready", i), b4.in_ready, vec[i].e_ready);
            chk($sformatf("vec%0d_valid", i), b4.out_valid, vec[i].e_valid);
            chk($sformatf("vec%0d_out", i), b4.out, vec[i].e_out);
            chk($sformatf("vec%0d_chan", i), b4.out_channel, vec[i].e_chan);
            b4.sel       = vec[i].sel;
            b4.in_valid  = vec[i].in_valid;
            b4.out_ready = vec[i].out_ready;
            step();
        end

        // Streaming at full rate
        pd = '0;
        ps = '0;
        for (int i = 0; i < 20; i++) begin
            chk("stream_ready", b4.in_ready, 1);
            if (i > 0) begin
                chk("stream_valid", b4.out_valid, 1);
                chk("stream_out", b4.out, pd);
                chk("stream_chan", b4.out_channel, ps);
            end
            b4.in_bus    = $urandom;
            b4.sel       = 2'(i % 4);
            b4.in_valid  = 1'b1;
            b4.out_ready = 1'b1;
            pd = b4.in_bus[(i % 4) * 8 +: 8];
            ps = 2'(i % 4);
            step();
        end
        b4.in_valid = 1'b0;
        chk("stream_last_out", b4.out, pd);
        chk("stream_last_chan", b4.out_channel, ps);
        step();
        chk("stream_drained", b4.out_valid, 0);

        // Reset with a full buffer
        b4.in_bus = BUS4;
        b4.out_ready = 1'b0;
        b4.in_valid = 1'b1;
        b4.sel = 2'd0;
        step();
        b4.sel = 2'd1;
        step();
        chk("full_ready", b4.in_ready, 0);
        chk("full_out", b4.out, 8'h11);
        b4.sel = 2'd2;
        rst = 1'b1;
        #1;
        chk("full_rst_ready", b4.in_ready, 0);
        step();
        rst = 1'b0;
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        #1;
        chk("post_rst_valid", b4.out_valid, 0);
        chk("post_rst_out", b4.out, 0);
        chk("post_rst_ready", b4.in_ready, 1);
        step();
        chk("post_rst_valid2", b4.out_valid, 0);
        step();
        chk("post_rst_valid3", b4.out_valid, 0);

        // Invalid select on the 3-channel instance
        do_reset();
        b3.in_bus = 24'h332211;
        b3.sel = 2'd3;
        b3.in_valid = 1'b1;
        b3.out_ready = 1'b1;
        #1;
        chk("bad_ready", b3.in_ready, 1);
        step();
        b3.in_valid = 1'b0;
        chk("bad_valid", b3.out_valid, 0);
        chk("bad_sel_error", b3.sel_error, 1);
        chk("bad_drop_count", b3.drop_count, 1);
        b3.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        b3.in_valid = 1'b0;
        chk("sat_drop_count", b3.drop_count, 255);
        chk("sat_valid", b3.out_valid, 0);
        b3.err_clr = 1'b1;
        step();
        b3.err_clr = 1'b0;
        chk("clr_sel_error", b3.sel_error, 0);
        chk("clr_drop_count", b3.drop_count, 0);
        b3.in_valid = 1'b1;
        step();
        step();
        chk("pre_clr_drop_count", b3.drop_count, 2);
        b3.err_clr = 1'b1;
        step();
        b3.err_clr = 1'b0;
        b3.in_valid = 1'b0;
        chk("clr_drop_sel_error", b3.sel_error, 1);
        chk("clr_drop_drop_count", b3.drop_count, 1);

        // Randomised traffic against a queue model
        do_reset();
        q.delete();
        m_err = 1'b0;
        m_drops = 0;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] e_out;
            logic [1:0] e_chan;
            logic       pop_m;
            logic       acc_m;
            int         s;
            e_out  = (q.size() > 0) ? q[0].d : 8'h00;
            e_chan = (q.size() > 0) ? q[0].c : 2'd0;
            chk("rnd_ready", b3.in_ready, (q.size() < 2) ? 1 : 0);
            chk("rnd_valid", b3.out_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_out", b3.out, e_out);
            chk("rnd_chan", b3.out_channel, e_chan);
            chk("rnd_sel_error", b3.sel_error, m_err);
            chk("rnd_drop_count", b3.drop_count, m_drops);

            s = $urandom_range(0, 3);
            b3.in_bus    = 24'($urandom);
            b3.sel       = 2'(s);
            b3.in_valid  = ($urandom_range(0, 3) != 0);
            b3.out_ready = ($urandom_range(0, 1) != 0);
            b3.err_clr   = ($urandom_range(0, 15) == 0);

            acc_m = b3.in_valid && (q.size() < 2);
            pop_m = (q.size() > 0) && b3.out_ready;
            if (pop_m) void'(q.pop_front());
            if (acc_m && s < 3) begin
                q.push_back('{b3.in_bus[s*8 +: 8], 2'(s)});
            end
            if (acc_m && s >= 3) begin
                m_err = 1'b1;
                m_drops = b3.err_clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (b3.err_clr) begin
                m_err = 1'b0;
                m_drops = 0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_out_mux_buf.md
# alu_out_mux_buf

Parametrised, registered successor to the ALU output selector. It picks one of `Channel_count` result channels per transfer and buffers the selection in a 2-entry FIFO (skid buffer) with valid/ready handshakes on both sides. Out-of-range selects are flagged and counted instead of being passed on. It sits between the ALU function-unit outputs and the system controller / TX FIFO path, so ALU results survive back-pressure without stalling the ALU.

## Interface
- `Output_data_width`, default 8: width of each channel and of `Out`.
- `Channel_count`, default 4: number of input channels, 2..16.
- `Sel_width`, default 2: width of `Sel` and `Out_channel`. Must satisfy 2^`Sel_width` >= `Channel_count`.
- `CLK` input, 1: single clock, rising edge.
- `RST` input, 1: synchronous, active-high reset.
- `In_bus` input, `Channel_count`*`Output_data_width`: channel k occupies bits [k*W +: W].
- `Sel` input, `Sel_width`: channel index for this transfer.
- `In_valid` input, 1: producer has a transfer.
- `In_ready` output, 1: block can accept a transfer this cycle.
- `Out` output, `Output_data_width`: head-entry data.
- `Out_channel` output, `Sel_width`: channel index of the head entry.
- `Out_valid` output, 1: head entry present.
- `Out_ready` input, 1: consumer takes the head this cycle.
- `Sel_error` output, 1: sticky out-of-range-select flag.
- `Drop_count` output, 8: saturating count of dropped transfers.
- `Err_clr` input, 1: clears `Sel_error` and `Drop_count`.

## Operation
- **Storage and occupancy.** The buffer has two entries (data + channel each), a 2-bit `count` (0..2), and head/tail pointers.
- **Ready.** `In_ready` = (`count` < 2) and not `RST`. It is derived from registered state only, with no combinational path from `Out_ready`.
- **Accept.** A transfer is accepted when `In_valid` && `In_ready`.
  - If `Sel` < `Channel_count`: write {`In_bus` slice `Sel`, `Sel`} at the tail, advance the tail, and increment `count`.
  - If `Sel` >= `Channel_count`: the handshake still completes and nothing is written. `Sel_error` becomes 1 and `Drop_count` increments, saturating at 255.
- **Pop.** A pop occurs when `Out_valid` && `Out_ready`: advance the head and decrement `count`.
- **Simultaneous push and pop:**
  - When `count`=1: `count` stays 1, and the new entry becomes the head next cycle.
  - When `count`=2: push is impossible because `In_ready`=0. The pop frees one slot, and `In_ready`=1 on the next cycle.
  - When `count`=0: no pop is possible. The pushed entry appears the next cycle; there is no bypass.
- **Outputs.**
  - `Out_valid` = (`count` != 0).
  - `Out`/`Out_channel` show the head entry when `Out_valid`=1, and are forced to 0 when `Out_valid`=0.
  - The head is stable while `Out_valid`=1 and `Out_ready`=0.
- **Error clearing.** When `Err_clr` is high, `Sel_error` goes to 0 and `Drop_count` to 0. If a drop occurs in the same cycle, the drop wins: `Sel_error`=1 and `Drop_count`=1.
- **Pointer wrap.** The pointers are 1 bit each and wrap naturally from 1 to 0.

## Timing
- **Reset values.** `RST` is sampled at the rising edge of `CLK`. While `RST` is high, and on the first cycle after it, all state is cleared:
  - `count`=0 and both pointers = 0.
  - `Out`=0, `Out_channel`=0, `Out_valid`=0.
  - `Sel_error`=0, `Drop_count`=0.
  - `In_ready`=0 while `RST` is high, and 1 in the first cycle after `RST` falls.
- **Reset mid-operation.** Buffered entries are discarded. A handshake in the reset cycle is ignored.
- **Latency.** Accept at edge N gives `Out_valid`=1 after edge N, so data is visible in cycle N+1 (1-cycle latency).
- **Throughput.** One transfer per cycle sustained when `Out_ready` is held at 1.
- **Back-pressure.** With `Out_ready`=0, two transfers are accepted, then `In_ready` drops in the cycle after the second accept.
- **Error timing.** `Sel_error` and `Drop_count` update at the edge that accepts the bad transfer.

## Test plan
- **Reset then single transfer.** After reset, apply `In_bus`={8'h44,8'h33,8'h22,8'h11}, `Sel`=2, `In_valid` for 1 cycle, with `Out_ready`=1 -> next cycle `Out`=8'h33, `Out_channel`=2, `Out_valid`=1 for exactly 1 cycle.
- **Back-pressure fill.** With `Out_ready`=0, push `Sel`=0, 1, 3 on consecutive cycles -> first two accepted and `In_ready`=0 on the third. Then set `Out_ready`=1 -> `Out` gives 8'h11 then 8'h22. The third transfer is accepted once `In_ready` returns, and `Out` gives 8'h44.
- **Streaming.** Keep `In_valid`=1 and `Out_ready`=1 for 20 cycles with cycling `Sel` -> `In_ready` stays 1, `Out` matches a reference model with 1-cycle lag, and nothing is lost or duplicated.
- **Invalid select.** With `Channel_count`=3 and `Sel_width`=2, send `Sel`=3 -> accepted, `Out_valid` stays 0, `Sel_error`=1, `Drop_count`=1. Send 300 bad transfers -> `Drop_count` saturates at 255.
- **Clear versus drop.** `Err_clr`=1 alone -> `Sel_error`=0, `Drop_count`=0. `Err_clr` in the same cycle as a bad `Sel` -> `Sel_error`=1, `Drop_count`=1.
- **Reset with a full buffer.** With `count`=2, assert `RST` for 1 cycle -> `Out_valid`=0, `Out`=0, `In_ready`=1 after release, and the old entries never reappear.
